// File: rtl/l2_mem_responder.sv
// -----------------------------------------------------------------------------
// l2_mem_responder
//   Behavioural L2 memory stand-in for the coherence bus controller's L2 port.
//   It accepts single-word reads and writes and answers after a fixed,
//   programmable number of BUSY cycles using the four-state L2 status protocol.
//   Bad requests are answered with a one-cycle ERROR and never touch memory:
//   a request is bad if both read and write are set, if it is misaligned, or
//   if it falls outside the window.
//
// Parameters
//   MEM_WORDS : depth of the backing store in 32-bit words (power of two, >= 2)
//   LATENCY   : number of BUSY cycles per access (1..255)
//   BASE_ADDR : byte address of word 0 (aligned to MEM_WORDS*4)
//
// Ports
//   CLK      in   1  clock, all logic on the rising edge
//   RST      in   1  synchronous active-high reset
//   l2REN    in   1  read request, held until ACCESS or ERROR is seen
//   l2WEN    in   1  write request, same hold rule
//   l2addr   in  32  byte address
//   l2store  in  32  write data
//   l2load   out 32  read data, valid while l2state == L2_ACCESS for a read
//   l2state  out  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
// -----------------------------------------------------------------------------
module l2_mem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [31:0] l2store,
  output logic [31:0] l2load,
  output logic [1:0]  l2state
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  // Window size in bytes. It is one bit wider than the address so that the
  // top-of-window comparison cannot overflow.
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_e;

  l2_state_e        state_q, state_d;
  logic             op_write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic [7:0]       cnt_q;
  logic [31:0]      mem [MEM_WORDS];

  logic        req_any;
  logic [31:0] offset;
  logic        bad_req;
  logic        accept;
  logic        commit;

  assign req_any = l2REN | l2WEN;
  // Unsigned wrap makes addresses below BASE_ADDR look huge, so a single
  // upper-bound compare covers both ends of the window.
  assign offset  = l2addr - BASE_ADDR;
  assign bad_req = (l2REN & l2WEN) | (l2addr[1:0] != 2'b00) | ({1'b0, offset} >= SPAN);

  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // that every register samples the pre-edge values of every other register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= L2_FREE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      L2_FREE: begin
        if (req_any) begin
          if (bad_req) begin
            state_d = L2_ERROR;
          end else begin
            state_d = L2_BUSY;
            accept  = 1'b1;
          end
        end
      end
      L2_BUSY: begin
        // The initiator dropping both requests aborts the access.
        if (!req_any)              state_d = L2_FREE;
        else if (cnt_q == 8'd0) begin
          state_d = L2_ACCESS;
          commit  = 1'b1;
        end
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR:  state_d = L2_FREE;
      default:   state_d = L2_FREE;
    endcase
  end

  // Latched request, the latency counter and the read-data register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      l2load     <= '0;
    end else begin
      if (accept) begin
        op_write_q <= l2WEN;
        idx_q      <= offset[IDX_W+1:2];
        data_q     <= l2store;
        cnt_q      <= 8'(LATENCY - 1);
      end else if (state_q == L2_BUSY && req_any && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (commit && !op_write_q) l2load <= mem[idx_q];
    end
  end

  // NOTE: the memory array has no reset, which lets it map onto block RAM.
  // Reset only gates the write, so a write that is pending when reset
  // arrives is discarded.
  always_ff @(posedge CLK) begin
    if (!RST && commit && op_write_q) mem[idx_q] <= data_q;
  end

  assign l2state = state_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_l2_mem_responder
//   Self-checking bench for l2_mem_responder. A reference model of the memory
//   contents and of the last read data is kept here. Expected state sequences
//   come from the protocol timing: LATENCY BUSY cycles, then one ACCESS cycle,
//   then FREE. A bad request gives one ERROR cycle, then FREE.
//   Inputs are driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_l2_mem_responder;

  localparam int          MEM_WORDS = 1024;
  localparam int          LATENCY   = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        l2REN = 1'b0;
  logic        l2WEN = 1'b0;
  logic [31:0] l2addr = '0;
  logic [31:0] l2store = '0;
  logic [31:0] l2load;
  logic [1:0]  l2state;

  int checks = 0;
  int errors = 0;

  // Reference model.
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] ref_load;

  always #5 CLK = ~CLK;

  l2_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LATENCY  (LATENCY),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .l2REN  (l2REN),
    .l2WEN  (l2WEN),
    .l2addr (l2addr),
    .l2store(l2store),
    .l2load (l2load),
    .l2state(l2state)
  );

  function automatic bit addr_bad(input logic [31:0] addr);
    longint a, lo, hi;
    a  = longint'(addr);
    lo = longint'(BASE_ADDR);
    hi = lo + longint'(MEM_WORDS) * 4;
    return (addr[1:0] != 2'b00) || (a < lo) || (a >= hi);
  endfunction

  function automatic int addr_idx(input logic [31:0] addr);
    return int'((addr - BASE_ADDR) >> 2);
  endfunction

  // A single access, entered and left just after a falling edge with the DUT
  // in FREE. Setting both raises l2REN and l2WEN together. Setting scramble
  // makes l2addr and l2store wander during BUSY. A read must only target a
  // word that the model already knows.
  task automatic run_op(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble, input string name);
    bit is_bad;
    int idx;
    logic [31:0] exp_load;
    is_bad = both || addr_bad(addr);
    l2REN   = both | ~wr;
    l2WEN   = both | wr;
    l2addr  = addr;
    l2store = wdata;
    if (is_bad) begin
      @(negedge CLK);
      checks++;
      if (l2state !== S_ERROR) begin
        errors++;
        $display("FAIL %s error_state got %0d want %0d", name, l2state, S_ERROR);
      end
      l2REN = 1'b0;
      l2WEN = 1'b0;
    end else begin
      idx = addr_idx(addr);
      for (int k = 1; k <= LATENCY; k++) begin
        @(negedge CLK);
        checks++;
        if (l2state !== S_BUSY) begin
          errors++;
          $display("FAIL %s busy_cycle%0d got %0d want %0d", name, k, l2state, S_BUSY);
        end
        if (scramble) begin
          l2addr  = $urandom;
          l2store = $urandom;
        end
      end
      @(negedge CLK);
      checks++;
      if (l2state !== S_ACCESS) begin
        errors++;
        $display("FAIL %s access_state got %0d want %0d", name, l2state, S_ACCESS);
      end
      if (wr) begin
        ref_mem[idx] = wdata;
      end else begin
        ref_load = ref_mem[idx];
      end
      exp_load = ref_load;
      checks++;
      if (l2load !== exp_load) begin
        errors++;
        $display("FAIL %s access_load got %h want %h", name, l2load, exp_load);
      end
      l2REN = 1'b0;
      l2WEN = 1'b0;
    end
    @(negedge CLK);
    checks++;
    if (l2state !== S_FREE || l2load !== ref_load) begin
      errors++;
      $display("FAIL %s after_free state %0d load %h want state %0d load %h",
               name, l2state, l2load, S_FREE, ref_load);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ref_load = 32'h0;
    checks++;
    if (l2state !== S_FREE || l2load !== 32'h0) begin
      errors++;
      $display("FAIL reset state %0d load %h want 0 and 0", l2state, l2load);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (l2state !== S_FREE) begin
        errors++;
        $display("FAIL idle_cycle%0d got %0d want %0d", i, l2state, S_FREE);
      end
    end
  endtask

  task automatic test_write_read();
    run_op(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, "wr40");
    run_op(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, "rd40");
  endtask

  task automatic test_errors();
    run_op(1'b0, 1'b0, 32'h42, 32'h0, 1'b0, "misaligned");
    run_op(1'b0, 1'b0, BASE_ADDR + MEM_WORDS * 4, 32'h0, 1'b0, "out_of_range");
    run_op(1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 1'b0, "ren_and_wen");
    run_op(1'b1, 1'b0, BASE_ADDR + MEM_WORDS * 4 - 4, 32'h7777_0001, 1'b0, "wr_top");
    run_op(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, "rd40_after_errors");
    run_op(1'b0, 1'b0, BASE_ADDR + MEM_WORDS * 4 - 4, 32'h0, 1'b0, "rd_top");
  endtask

  task automatic test_abort();
    run_op(1'b1, 1'b0, 32'h80, 32'hCAFE_0080, 1'b0, "wr80_prior");
    l2WEN   = 1'b1;
    l2addr  = 32'h80;
    l2store = 32'h1111_1111;
    repeat (2) @(negedge CLK);
    checks++;
    if (l2state !== S_BUSY) begin
      errors++;
      $display("FAIL abort_busy got %0d want %0d", l2state, S_BUSY);
    end
    l2WEN = 1'b0;
    @(negedge CLK);
    checks++;
    if (l2state !== S_FREE || l2load !== ref_load) begin
      errors++;
      $display("FAIL abort_free state %0d load %h want %0d %h", l2state, l2load, S_FREE, ref_load);
    end
    run_op(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, "rd80_after_abort");
  endtask

  task automatic test_reset_mid_busy();
    run_op(1'b1, 1'b0, 32'hC0, 32'h0C0C_0C0C, 1'b0, "wrC0_prior");
    run_op(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, "rd40_nonzero_load");
    l2WEN   = 1'b1;
    l2addr  = 32'hC0;
    l2store = 32'h2222_2222;
    repeat (2) @(negedge CLK);
    RST   = 1'b1;
    l2WEN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    ref_load = 32'h0;
    checks++;
    if (l2state !== S_FREE || l2load !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy state %0d load %h want 0 and 0", l2state, l2load);
    end
    run_op(1'b0, 1'b0, 32'hC0, 32'h0, 1'b0, "rdC0_after_rst");
  endtask

  task automatic test_back_to_back();
    int access_cyc [$];
    int first_gap;
    l2REN  = 1'b1;
    l2addr = 32'h40;
    for (int c = 1; c <= 2 * (LATENCY + 2) + 1; c++) begin
      @(negedge CLK);
      if (c == 2) l2addr = 32'h80;  // a change while BUSY must be ignored
      if (l2state === S_ACCESS) begin
        access_cyc.push_back(c);
        checks++;
        if (l2load !== ref_mem[addr_idx(32'h40)]) begin
          errors++;
          $display("FAIL b2b_load cycle%0d got %h want %h", c, l2load, ref_mem[addr_idx(32'h40)]);
        end
        l2addr = 32'h40;
      end
      if (c == LATENCY + 2) begin
        checks++;
        if (l2state !== S_FREE) begin
          errors++;
          $display("FAIL b2b_gap_free got %0d want %0d", l2state, S_FREE);
        end
      end
      if (c == 2 * (LATENCY + 2) - 1) l2REN = 1'b0;
    end
    ref_load = ref_mem[addr_idx(32'h40)];
    first_gap = (access_cyc.size() >= 2) ? access_cyc[1] - access_cyc[0] : -1;
    checks++;
    if (access_cyc.size() != 2 || access_cyc[0] != LATENCY + 1 || first_gap != LATENCY + 2) begin
      errors++;
      $display("FAIL b2b_spacing count %0d first %0d gap %0d want 2 %0d %0d",
               access_cyc.size(), (access_cyc.size() > 0) ? access_cyc[0] : -1,
               first_gap, LATENCY + 1, LATENCY + 2);
    end
    @(negedge CLK);
    checks++;
    if (l2state !== S_FREE) begin
      errors++;
      $display("FAIL b2b_end got %0d want %0d", l2state, S_FREE);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int sel;
    for (int i = 0; i < 16; i++)
      run_op(1'b1, 1'b0, BASE_ADDR + 32'(i * 4), $urandom, 1'b0, "rnd_init");
    for (int n = 0; n < 40; n++) begin
      addr = BASE_ADDR + 32'($urandom_range(0, 15) * 4);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      run_op(1'b0, 1'b0, addr | 32'($urandom_range(1, 3)), 32'h0, 1'b0, "rnd_misalign");
      else if (sel == 1) run_op(1'b1, 1'b1, addr, $urandom, 1'b0, "rnd_both");
      else               run_op(sel[0], 1'b0, addr, $urandom, $urandom_range(0, 1) == 1, "rnd_op");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_abort();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Behavioural L2 memory responder for the coherence bus controller's L2 port. It accepts single-word read/write requests on `l2REN`/`l2WEN`/`l2addr`/`l2store` and answers through `l2state`/`l2load` using the four-state L2 status protocol. It sits below the bus controller in multicore simulation and FPGA builds, standing in for a real L2 with a programmable fixed latency and error detection.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of backing store in 32-bit words; power of two.
- `LATENCY`, 4: number of BUSY cycles per access; legal range 1..255.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `MEM_WORDS*4`.

Ports:
- `CLK`  in  1  clock. Single clock domain; all logic on rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `l2REN`  in  1  read request; held by the initiator until it sees ACCESS or ERROR.
- `l2WEN`  in  1  write request; same hold rule.
- `l2addr`  in  32  byte address.
- `l2store`  in  32  write data.
- `l2load`  out  32  read data; valid while `l2state`==L2_ACCESS for a read.
- `l2state`  out  2  status: L2_FREE=0, L2_BUSY=1, L2_ACCESS=2, L2_ERROR=3.

## Operation
- States FREE, BUSY, ACCESS, ERROR; `l2state` is the registered state encoding.
- Registers: latched op (read/write), latched word index, latched store data, 8-bit down-counter, `l2load` register, `MEM_WORDS`x32 array.
- FREE: sample request each cycle.
  - Neither request: stay FREE.
  - `l2REN`&`l2WEN` both high, `l2addr[1:0]`!=0, or `l2addr` outside [`BASE_ADDR`, `BASE_ADDR`+`MEM_WORDS*4`): go ERROR; no memory access.
  - Otherwise: latch op, index = (`l2addr`-`BASE_ADDR`)>>2, store data; counter=`LATENCY`-1; go BUSY.
- BUSY: `l2addr`/`l2store` changes ignored (latched values used).
  - Both requests low: abort -> FREE; no write commits; `l2load` unchanged.
  - counter!=0: decrement, stay BUSY.
  - counter==0: go ACCESS; on that same edge a write commits latched data to mem[index], a read loads `l2load` <= mem[index].
- ACCESS: exactly one cycle, then FREE unconditionally (a still-asserted request is not re-accepted until sampled in FREE).
- ERROR: exactly one cycle, then FREE.
- `l2load` holds its last value in all states except the ACCESS-entry edge of a read; writes never change `l2load`.
- Memory array is not reset; contents undefined until written.

## Timing
- Reset values: `l2state`=L2_FREE, `l2load`=32'h0, counter=0, latched op/index/data=0. Reset in any state returns to FREE next cycle and discards a pending write.
- Request sampled high in FREE at edge 0 -> BUSY for cycles 1..`LATENCY` -> ACCESS in cycle `LATENCY`+1 -> FREE in cycle `LATENCY`+2.
- Earliest next acceptance: request sampled at edge `LATENCY`+2; peak throughput one access per `LATENCY`+2 cycles.
- Error path: bad request at edge 0 -> ERROR in cycle 1 -> FREE in cycle 2.
- Read-after-write to same index sees new data (write commits before the following read can be accepted).
- Counter width 8 bits; no wrap occurs within legal `LATENCY`.

## Test plan
- Reset then idle: `RST` high 2 cycles -> `l2state`=0, `l2load`=0; stays FREE with requests low.
- Write 32'hDEAD_BEEF to 0x40 (`LATENCY`=4), then read 0x40 -> BUSY 4 cycles each, ACCESS in cycle 5; read ACCESS shows `l2load`=32'hDEAD_BEEF; FREE in cycle 6.
- Misaligned read 0x42, out-of-range read `BASE_ADDR`+`MEM_WORDS*4`, and `l2REN`&`l2WEN`=1 -> each gives ERROR for exactly 1 cycle then FREE; memory and `l2load` unchanged.
- Write 32'h1111_1111 to 0x80, drop `l2WEN` in BUSY cycle 2 -> FREE next cycle; subsequent read of 0x80 returns prior contents, not 32'h1111_1111.
- Assert `RST` during BUSY of a write of 32'h2222_2222 -> FREE next cycle, `l2load`=0; write not committed.
- Hold `l2REN` continuously across ACCESS -> FREE for one cycle, then a second read accepted; ACCESS pulses spaced `LATENCY`+2 cycles apart; `l2addr` changed mid-BUSY has no effect on returned data.
